// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI mode-0 slave.
package spi_pkg;

  localparam int unsigned SPI_BITS = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with registered history for rise/fall pulses.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_rtl.sv
// SPI mode-0 slave: oversamples sclk/ss/mosi on i_clk, shifts one BITS-wide frame per ss-low window.
//
// state | meaning
// IDLE  | waiting for an ss falling edge, o_miso held low
// SHIFT | frame in progress, sampling mosi on sclk rise, driving miso on sclk fall
// DONE  | full frame received, sclk ignored until ss rises
module spi_slave_rtl
  import spi_pkg::*;
#(
  parameter int BITS = SPI_BITS
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sclk,
  input  logic            i_mosi,
  input  logic            i_ss,
  output logic            o_miso,
  input  logic [BITS-1:0] i_data,
  input  logic            i_load,
  output logic [BITS-1:0] o_data,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_err
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ss_rise, ss_fall, ss_lvl;
  logic mosi_lvl;
  logic [1:0] mosi_edge_unused;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .d_i(i_sclk),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .i_clk(i_clk), .i_rst(i_rst), .d_i(i_ss),
    .q_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .d_i(i_mosi),
    .q_o(mosi_lvl), .rise_o(mosi_edge_unused[1]), .fall_o(mosi_edge_unused[0])
  );

  spi_state_e      state_q, state_d;
  logic [BITS-1:0] tx_buf_q;
  logic [BITS-1:0] tx_sr_q, tx_sr_d;
  logic [BITS-1:0] rx_sr_q, rx_sr_d;
  logic [BITS-1:0] data_q, data_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            miso_q, miso_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [1:0]      settle_q, settle_d;
  logic            armed_q, armed_d;
  logic [BITS-1:0] tx_word;

  // A load strobe landing on the start cycle must win over the stored buffer.
  assign tx_word = i_load ? i_data : tx_buf_q;

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    miso_d    = miso_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    // Synchronizer outputs are only trusted once flushed; an ss held low through reset never arms.
    armed_d   = armed_q | ((settle_q == 2'd2) & ss_lvl);

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall && armed_q) begin
          state_d   = SHIFT;
          tx_sr_d   = tx_word;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          miso_d    = tx_word[BITS-1];
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[BITS-2:0], mosi_lvl};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_ONE;
          if (bit_cnt_q == CNT_LAST) begin
            state_d = DONE;
            data_d  = rx_sr_d;
            valid_d = 1'b1;
            miso_d  = 1'b0;
          end
        end else if (sclk_fall) begin
          tx_sr_d = tx_sr_q << 1;
          miso_d  = tx_sr_q[BITS-2];
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (ss_rise) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      tx_buf_q  <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      settle_q  <= 2'd0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (i_load) tx_buf_q <= i_data;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      miso_q    <= miso_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
    end
  end

  assign o_miso  = miso_q;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_busy  = (state_q != IDLE);

endmodule
